// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; shifts run 1 bit/cycle unless
// ALU_EXEC_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SLL  = 4'h2,
        OP_SLT  = 4'h3,
        OP_SLTU = 4'h4,
        OP_XOR  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_OR   = 4'h8,
        OP_AND  = 4'h9,
        OP_SUB  = 4'hA
    } op_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]          rd_q, rd_d;
    logic                illegal_q, illegal_d;

    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift_in;
    logic                is_illegal_in;
    logic                start_shift;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN-1:0]     shift_step;

    assign shamt         = op_b[SHAMT_W-1:0];
    assign is_shift_in   = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);
    assign is_illegal_in = (operation > OP_SUB);

`ifdef ALU_EXEC_FAST_SHIFT_EN
    assign start_shift = 1'b0;
`else
    assign start_shift = is_shift_in && (shamt != '0);
`endif

    // Single-cycle result for the incoming operation; the result register
    // doubles as the shift register while iterating.
    always_comb begin
        alu_res = '0;
        case (operation)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
            // Only zero-count shifts complete here, so the operand passes through.
            OP_SLL:  alu_res = op_a;
            OP_SRL:  alu_res = op_a;
            OP_SRA:  alu_res = op_a;
`endif
            default: alu_res = '0;
        endcase
    end

    // The MSB of the shift register stays equal to op_a's sign bit, so SRA
    // replicating it is the same as replicating the captured sign.
    always_comb begin
        shift_step = result_q;
        case (op_q)
            OP_SLL:  shift_step = {result_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, result_q[XLEN-1:1]};
            OP_SRA:  shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: shift_step = result_q;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = operation;
                    rd_d      = rd_in;
                    illegal_d = is_illegal_in;
                    cnt_d     = shamt;
                    if (start_shift) begin
                        result_d = op_a;
                        state_d  = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shift_step;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset as well, because the result
            // and tag outputs must read zero after reset, not stale data.
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            result_q  <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result     = result_q;
    assign rd_out     = rd_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      operation;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            illegal_op;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.XLEN(XLEN), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd_in      (rd_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .rd_out     (rd_out),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd1:    return a + b;
            4'd2:    return a << sh;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return a - b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        int lat;
        lat = 1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && (b % 32) != 0)
            lat = 1 + int'(b % 32);
`endif
        return lat;
    endfunction

    // Issue one op at a negedge, measure latency, hold backpressure, then handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int hold);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
        int          lat;
        bit          busy_ok;
        bit          stable_ok;
        exp_res = ref_result(op, a, b);
        exp_ill = (op >= 4'd11);
        exp_lat = ref_latency(op, b);

        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        operation = op;
        op_a      = a;
        op_b      = b;
        rd_in     = rd;
        out_ready = 1'b0;
        @(negedge clk);
        // Garbage on the inputs while busy must not disturb the captured op.
        operation = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        rd_in     = 5'($urandom);
        lat       = 1;
        busy_ok   = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_in_ready"}, busy_ok, 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_rd_out"}, rd_out, rd);
        check({tag, "_illegal"}, illegal_op, exp_ill);

        stable_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== exp_res || rd_out !== rd ||
                illegal_op !== exp_ill || in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        check({tag, "_hold_stable"}, stable_ok, 1);

        // in_valid stays high across the handshake edge: it must not be taken.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_after_hs_valid"}, out_valid, 0);
        check({tag, "_after_hs_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = 4'd0;
        op_a      = '0;
        op_b      = '0;
        rd_in     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_rd_out", rd_out, 0);
        check("rst_illegal", illegal_op, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 0);
        check("add_wrap_const", result, 32'h0000_0001);
        run_op("slt", 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4, 0);
        run_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1);
        run_op("sra31", 4'd7, 32'h8000_0000, 32'h0000_001F, 5'd6, 0);
        run_op("sll0", 4'd2, 32'h0000_1234, 32'h0000_0020, 5'd8, 0);
        run_op("illegal", 4'd12, $urandom, $urandom, 5'd7, 5);
        run_op("sub", 4'd10, 32'h0000_0000, 32'h0000_0001, 5'd0, 2);
        run_op("nop", 4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 0);

        // Reset in the middle of an SRL by 16.
        in_valid  = 1'b1;
        operation = 4'd6;
        op_a      = 32'hA5A5_A5A5;
        op_b      = 32'h0000_0010;
        rd_in     = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifndef ALU_EXEC_FAST_SHIFT_EN
        check("midshift_busy", in_ready, 0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_rd_out", rd_out, 0);
        check("midrst_illegal", illegal_op, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_still_idle", out_valid, 0);
        run_op("xor_after_rst", 4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 5'd10, 0);
        check("xor_const", result, 32'h0000_FF00);

        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if (i % 4 == 0) r_a = 32'h8000_0000 | $urandom;
            run_op("rand", r_op, r_a, r_b, 5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the I-type/R-type operation decoders; consumes the 4-bit operation code plus two operands and produces a registered result.
- Valid/ready handshake on both sides; single-cycle ops complete in 1 cycle, shifts run iteratively at 1 bit/cycle.
- Result and destination tag go to the writeback stage.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; shift amount is op_b[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation/operands valid.
- in_ready  output  1  unit can accept a new operation.
- operation  input  4  ALU op code from the decoder.
- op_a  input  XLEN  operand A (rs1).
- op_b  input  XLEN  operand B (rs2 or sign-extended immediate).
- rd_in  input  5  destination register tag.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts result.
- result  output  XLEN  registered result.
- rd_out  output  5  tag captured with the op.
- illegal_op  output  1  captured op code was unsupported; qualified by out_valid.

Behaviour:
- Op encoding:
  - 0000 NOP: result 0.
  - 0001 ADD, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010 SUB: a-b.
  - 1011–1111 illegal: result 0, illegal_op=1.
- Arithmetic: all ops modulo 2^XLEN, carry discarded. SLT/SLTU write 1 or 0 in bit 0, upper bits zero.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture op, operands, rd_in, and shift count = op_b[SHAMT_W-1:0].
  - Non-shift op, or shift with count 0: compute result, go to DONE.
  - Shift with count ≠ 0: load shift register with op_a, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: shift 1 bit and decrement count. SLL fills with 0, SRL fills with 0, SRA replicates the sign bit of the captured op_a.
  - When count reaches 1, the final shift is performed and the FSM enters DONE.
- DONE:
  - out_valid=1; result, rd_out, and illegal_op are held stable until out_ready=1.
  - On out_valid&out_ready: return to IDLE. No new op is accepted in the same cycle.
- Latency, from acceptance edge to out_valid:
  - Non-shift ops: 1 cycle.
  - Shifts: 1+shamt cycles.
- Throughput: one op per (latency+1) cycles minimum.
- Backpressure: out_ready low holds DONE indefinitely; outputs do not change.
- Inputs are ignored while in_ready=0 and do not alter captured state.
- Reset (rst_n=0 at a rising edge), from any state including mid-SHIFT:
  - State→IDLE.
  - out_valid=0, result=0, rd_out=0, illegal_op=0, internal count=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Any in-flight op is discarded.
- rd_in=0 is passed through unchanged; write suppression is the writeback stage's job.

Optional Feature:
- Macro: ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter, the SHIFT state is never entered, and all ops have 1-cycle latency.
- Undefined: iterative 1-bit/cycle shifter as described above.
- Results are identical in both builds; only latency differs.

Test Plan:
- ADD: op_a=0xFFFFFFFF, op_b=0x00000002, op 0001 → next cycle out_valid=1, result=0x00000001, illegal_op=0.
- SLT vs SLTU: op_a=0xFFFFFFFF, op_b=0x00000001.
  - op 0011 → result=1.
  - op 0100 → result=0.
- SRA: op_a=0x80000000, op_b=0x0000001F, op 0111.
  - Default build: out_valid after 32 cycles, result=0xFFFFFFFF, in_ready=0 throughout.
  - With the macro defined: out_valid after 1 cycle.
- SLL with shamt 0: op_a=0x1234, op_b=0x00000020 (low 5 bits=0) → 1-cycle latency, result=0x1234.
- Backpressure and illegal op: op 1100, rd_in=7, out_ready held 0 for 5 cycles.
  - out_valid=1 stays stable with result=0, illegal_op=1, rd_out=7.
  - in_ready stays 0 throughout.
  - Raising out_ready causes 1 handshake, then IDLE.
- Reset mid-shift: SRL with op_b=0x10, assert rst_n=0 on the 4th SHIFT cycle.
  - Next cycle: out_valid=0, result=0, in_ready=1.
  - A subsequent XOR of 0xF0F0 and 0x0FF0 → result=0xFF00.
